// File: rtl/sc_fetch_if.sv
// Instruction-memory request/acknowledge channel between the fetch stage and instruction memory.
interface sc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/sc_fetch.sv
// Instruction-fetch stage: holds the PC, fetches over req/ack, holds the word
// while downstream executes it, and computes the next PC.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | just out of reset, fetch starts on the next edge
// FETCH | imem_req high at address pc, waiting for imem_ack
// EXEC  | inst valid and executing; leaves when stall is low
// HALT  | misaligned jr target seen; err high until reset
module sc_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    sc_fetch_if.master  imem,
    input  logic [1:0]  pcsource,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        err,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] br_off;
    logic [31:0] npc;
    logic        jr_bad;

    assign pc4            = pc + 32'd4;
    assign imem.imem_addr = pc;
    assign br_off         = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign jr_bad         = (pcsource == 2'b10) && (rs_data[1:0] != 2'b00);

    // Next-PC select driven by the control unit's decode of the held instruction.
    always_comb begin
        npc = pc4;
        case (pcsource)
            2'b00:   npc = pc4;
            2'b01:   npc = pc4 + br_off;
            2'b10:   npc = rs_data;
            default: npc = {pc4[31:28], inst[25:0], 2'b00};
        endcase
    end

    // Fetch/execute sequencer with all outputs registered.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            pc            <= PC_RESET;
            inst          <= 32'd0;
            inst_valid    <= 1'b0;
            imem.imem_req <= 1'b0;
            err           <= 1'b0;
            inst_count    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state         <= FETCH;
                    imem.imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        inst          <= imem.imem_rdata;
                        inst_valid    <= 1'b1;
                        imem.imem_req <= 1'b0;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        inst_valid <= 1'b0;
                        if (jr_bad) begin
                            // pc and inst_count keep the faulting instruction's view
                            err   <= 1'b1;
                            state <= HALT;
                        end else begin
                            pc            <= npc;
                            inst_count    <= inst_count + 32'd1;
                            imem.imem_req <= 1'b1;
                            state         <= FETCH;
                        end
                    end
                end
                default: begin
                    imem.imem_req <= 1'b0;
                    inst_valid    <= 1'b0;
                    err           <= 1'b1;
                end
            endcase
        end
    end

endmodule
